// File: rtl/types_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
package types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters, with a starvation
// counter that lets a waiting fetch through after IF_STARVE_MAX data wins.
module mem_arb_prio
  import types_pkg::*;
#(
  parameter int unsigned IF_STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       idle,
  output arb_owner_t winner,
  output logic       if_gnt,
  output logic       dm_gnt
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  always_comb begin
    starved = (starve_cnt == STARVE_W'(IF_STARVE_MAX));
    winner  = (dm_req && !(if_req && starved)) ? OWN_DM : OWN_IF;
    if_gnt  = idle && if_req && (winner == OWN_IF);
    dm_gnt  = idle && dm_req && (winner == OWN_DM);
  end

  // The counter only rises while a fetch is actually waiting; the starved
  // compare blocks further data grants once it saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt || (idle && !if_req)) begin
      starve_cnt <= '0;
    end else if (dm_gnt && if_req && !starved) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// tracking a single outstanding transaction with a response timeout.
module mem_port_arbiter
  import types_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned IF_STARVE_MAX = 4,
  parameter int unsigned TIMEOUT_CYC   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t          state, state_nxt;
  arb_owner_t          owner_q, winner;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [31:0]         tcnt;
  logic                ready_q;
  logic                out_en;
  logic                idle;
  logic                if_gnt, dm_gnt;
  logic                done, abort, timed_out;

  // Outputs stay quiet while reset is low and for the first cycle after it.
  assign out_en = rst_n && ready_q;
  assign idle   = out_en && (state == IDLE);

  mem_arb_prio #(
    .IF_STARVE_MAX(IF_STARVE_MAX)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .if_req(if_req_i),
    .dm_req(dm_req_i),
    .idle  (idle),
    .winner(winner),
    .if_gnt(if_gnt),
    .dm_gnt(dm_gnt)
  );

  assign if_gnt_o = if_gnt;
  assign dm_gnt_o = dm_gnt;

  always_comb begin
    state_nxt   = state;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done        = 1'b0;
    abort       = 1'b0;
    timed_out   = (TIMEOUT_CYC != 0) && (tcnt == 32'(TIMEOUT_CYC - 1));

    if (out_en) begin
      case (state)
        IDLE: begin
          if (if_gnt || dm_gnt) state_nxt = REQ;
        end
        REQ: begin
          mem_req_o   = 1'b1;
          mem_we_o    = we_q;
          mem_be_o    = be_q;
          mem_addr_o  = addr_q;
          mem_wdata_o = wdata_q;
          // A response coinciding with the grant completes immediately;
          // a response without the grant is not ours and is ignored.
          if (mem_gnt_i && mem_rvalid_i) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else if (timed_out) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end else if (mem_gnt_i) begin
            state_nxt = RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_i) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else if (timed_out) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if_rvalid_o = (done || abort) && (owner_q == OWN_IF);
    if_err_o    = abort && (owner_q == OWN_IF);
    if_rdata_o  = (done && owner_q == OWN_IF) ? mem_rdata_i : '0;
    dm_rvalid_o = (done || abort) && (owner_q == OWN_DM);
    dm_err_o    = abort && (owner_q == OWN_DM);
    dm_rdata_o  = (done && owner_q == OWN_DM && !we_q) ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tcnt    <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      state   <= state_nxt;
      if (if_gnt || dm_gnt) begin
        owner_q <= winner;
        if (winner == OWN_DM) begin
          we_q    <= dm_we_i;
          be_q    <= dm_be_i;
          addr_q  <= dm_addr_i;
          wdata_q <= dm_wdata_i;
        end else begin
          we_q    <= 1'b0;
          be_q    <= '1;
          addr_q  <= if_addr_i;
          wdata_q <= '0;
        end
      end
      if (state == IDLE) tcnt <= '0;
      else               tcnt <= tcnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: dut_a uses the default timeout,
// dut_b shares its stimulus with an 8-cycle timeout.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        a_if_gnt, a_if_rvalid, a_if_err, a_dm_gnt, a_dm_rvalid, a_dm_err;
  logic        a_mem_req, a_mem_we;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_if_gnt, b_if_rvalid, b_if_err, b_dm_gnt, b_dm_rvalid, b_dm_err;
  logic        b_mem_req, b_mem_we;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic [139:0] a_all, b_all;

  assign a_all = {a_if_gnt, a_if_rvalid, a_if_rdata, a_if_err, a_dm_gnt, a_dm_rvalid,
                  a_dm_rdata, a_dm_err, a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata};
  assign b_all = {b_if_gnt, b_if_rvalid, b_if_rdata, b_if_err, b_dm_gnt, b_dm_rvalid,
                  b_dm_rdata, b_dm_err, b_mem_req, b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_STARVE_MAX(4), .TIMEOUT_CYC(64)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata), .if_err_o(a_if_err),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(a_dm_gnt), .dm_rvalid_o(a_dm_rvalid),
    .dm_rdata_o(a_dm_rdata), .dm_err_o(a_dm_err),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_STARVE_MAX(4), .TIMEOUT_CYC(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata), .if_err_o(b_if_err),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(b_dm_gnt), .dm_rvalid_o(b_dm_rvalid),
    .dm_rdata_o(b_dm_rdata), .dm_err_o(b_dm_err),
    .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct packed {
    logic        dm;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  // Every response from dut_a is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t got, want;
    if (mon_en && (a_if_rvalid || a_dm_rvalid)) begin
      got.dm   = a_dm_rvalid;
      got.data = a_dm_rvalid ? a_dm_rdata : a_if_rdata;
      got.err  = a_dm_rvalid ? a_dm_err : a_if_err;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got dm=%0d data=%h err=%0d, required no response",
                 got.dm, got.data, got.err);
      end else begin
        want = exp_q.pop_front();
        if ((a_if_rvalid && a_dm_rvalid) || got !== want) begin
          errors++;
          $display("FAIL rsp_match: got if_rv=%0d dm_rv=%0d data=%h err=%0d, required dm=%0d data=%h err=%0d",
                   a_if_rvalid, a_dm_rvalid, got.data, got.err, want.dm, want.data, want.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic dm, input logic [31:0] data, input logic err);
    exp_t e;
    e.dm = dm; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h20;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = '1;
    repeat (2) tick();
    sample();
    checks++;
    if (a_all !== '0 || b_all !== '0) begin
      errors++; $display("FAIL reset_outputs: got a=%h b=%h, required 0", a_all, b_all);
    end
    tick(); rst_n = 1'b1;
    sample();
    checks++;
    if (a_all !== '0 || b_all !== '0) begin
      errors++; $display("FAIL post_reset_outputs: got a=%h b=%h, required 0", a_all, b_all);
    end
    if_req = 1'b0; dm_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mon_en = 1'b1;
    tick(); sample();
    checks++;
    if (a_all !== '0) begin
      errors++; $display("FAIL idle_outputs: got %h, required 0", a_all);
    end
  endtask

  task automatic test_single_fetch();
    tick(); if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    sample();
    checks++;
    if ({a_if_gnt, a_dm_gnt} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt: got if/dm=%b, required 10", {a_if_gnt, a_dm_gnt});
    end
    tick(); if_req = 1'b0;
    sample();
    checks++;
    if ({a_mem_req, a_mem_we, a_mem_be, a_mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      errors++; $display("FAIL fetch_mem_req: got req=%0d we=%0d be=%h addr=%h, required 1 0 f 100",
                         a_mem_req, a_mem_we, a_mem_be, a_mem_addr);
    end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    sample();
    checks++;
    if ({a_dm_rvalid, a_mem_req} !== 2'b00) begin
      errors++; $display("FAIL fetch_no_dm_rvalid: got dm_rv/mem_req=%b, required 00", {a_dm_rvalid, a_mem_req});
    end
    tick(); mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL fetch_drained: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_store();
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h2004; dm_wdata = 32'h1234;
    mem_gnt = 1'b1;
    push(1'b1, 32'h0, 1'b0);
    sample();
    checks++;
    if ({a_if_gnt, a_dm_gnt} !== 2'b01) begin
      errors++; $display("FAIL store_gnt: got if/dm=%b, required 01", {a_if_gnt, a_dm_gnt});
    end
    tick(); dm_req = 1'b0; dm_we = 1'b0;
    sample();
    checks++;
    if ({a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata} !==
        {1'b1, 1'b1, 4'b0011, 32'h2004, 32'h1234}) begin
      errors++; $display("FAIL store_mem_req: got req=%0d we=%0d be=%b addr=%h wdata=%h, required 1 1 0011 2004 1234",
                         a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata);
    end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick(); mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL store_drained: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    logic        want_if;
    logic [31:0] data;
    if_addr = 32'h400; dm_addr = 32'h800; dm_we = 1'b0; dm_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      want_if = (k % 5 == 4);
      data = 32'hC0DE_0000 + 32'(k);
      tick(); if_req = 1'b1; dm_req = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      push(!want_if, data, 1'b0);
      sample();
      checks++;
      if ({a_if_gnt, a_dm_gnt, b_if_gnt, b_dm_gnt} !== (want_if ? 4'b1010 : 4'b0101)) begin
        errors++; $display("FAIL contention_gnt[%0d]: got a/b if,dm=%b, required %b", k,
                           {a_if_gnt, a_dm_gnt, b_if_gnt, b_dm_gnt}, want_if ? 4'b1010 : 4'b0101);
      end
      tick(); mem_gnt = 1'b1;
      sample();
      checks++;
      if ({a_mem_req, a_mem_addr} !== {1'b1, want_if ? 32'h400 : 32'h800}) begin
        errors++; $display("FAIL contention_addr[%0d]: got req=%0d addr=%h, required 1 %h", k,
                           a_mem_req, a_mem_addr, want_if ? 32'h400 : 32'h800);
      end
      tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
    end
    tick(); if_req = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL contention_drained: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int req_cycles = 0;
    tick(); if_req = 1'b1; if_addr = 32'h300; mem_gnt = 1'b0;
    push(1'b0, 32'h5A5A_1234, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if_req = 1'b0;
      mem_gnt = (c == 4);
      mem_rvalid = (c == 9);
      mem_rdata = (c == 9) ? 32'h5A5A_1234 : 32'h0;
      sample();
      if (a_mem_req) req_cycles++;
    end
    tick(); mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    checks++;
    if (req_cycles != 4) begin
      errors++; $display("FAIL stall_req_cycles: got %0d, required 4", req_cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_drained: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok = 1'b1;
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; mem_gnt = 1'b0;
    push(1'b1, 32'h0, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      tick(); dm_req = 1'b0;
      sample();
      if (c < 8 && (b_dm_rvalid || b_dm_err || !b_mem_req)) ok = 1'b0;
      if (c == 8) begin
        checks++;
        if ({b_dm_rvalid, b_dm_err, b_dm_rdata, b_if_rvalid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
          errors++; $display("FAIL timeout_b_abort: got rv=%0d err=%0d rdata=%h if_rv=%0d, required 1 1 0 0",
                             b_dm_rvalid, b_dm_err, b_dm_rdata, b_if_rvalid);
        end
      end
      if (c == 9 && b_mem_req) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL timeout_b_window: got early abort or wrong mem_req, required quiet until cycle 8");
    end
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    sample();
    checks++;
    if ({a_if_rvalid, a_dm_rvalid, b_if_rvalid, b_dm_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL late_rvalid_ignored: got %b, required 0000",
                         {a_if_rvalid, a_dm_rvalid, b_if_rvalid, b_dm_rvalid});
    end
    tick(); mem_rvalid = 1'b0; mem_rdata = '0;
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      tick(); sample(); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_a_abort: got %0d pending after bound, required 0", exp_q.size());
    end
    tick(); if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1;
    push(1'b0, 32'hCAFE_F00D, 1'b0);
    tick(); if_req = 1'b0;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    sample();
    checks++;
    if ({b_if_rvalid, b_if_err, b_if_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL timeout_next_fetch: got rv=%0d err=%0d data=%h, required 1 0 cafef00d",
                         b_if_rvalid, b_if_err, b_if_rdata);
    end
    tick(); mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset_mid_resp();
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; mem_gnt = 1'b1;
    tick(); dm_req = 1'b0;
    tick(); mem_gnt = 1'b0; rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    sample();
    checks++;
    if (a_all !== '0 || b_all !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got a=%h b=%h, required 0", a_all, b_all);
    end
    tick(); rst_n = 1'b1;
    sample();
    checks++;
    if (a_all !== '0 || b_all !== '0) begin
      errors++; $display("FAIL mid_post_reset_outputs: got a=%h b=%h, required 0", a_all, b_all);
    end
    tick();
    sample();
    checks++;
    if ({a_if_rvalid, a_dm_rvalid, b_if_rvalid, b_dm_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_rvalid_ignored: got %b, required 0000",
                         {a_if_rvalid, a_dm_rvalid, b_if_rvalid, b_dm_rvalid});
    end
    tick(); mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_stall();
    test_timeout();
    test_reset_mid_resp();
    tick(); sample();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
